// File: rtl/nios2_oci_dct_pkg.sv
// Shared definitions for the Nios II OCI trace-capture packer.
// Contents: atom and word geometry, counter and output widths, the
// controller state type, and the "word full" count value.
package nios2_oci_dct_pkg;

  localparam int ATOM_W         = 2;
  localparam int ATOMS_PER_WORD = 15;
  localparam int BUF_W          = ATOM_W * ATOMS_PER_WORD;
  localparam int CNT_W          = 4;
  localparam int TW_W           = CNT_W + BUF_W;

  localparam logic [CNT_W-1:0] CNT_FULL = 4'd15;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    ENDED   = 2'd2
  } dct_state_t;

endpackage

// File: rtl/nios2_oci_dct_outreg.sv
// Single-entry output holding register with a valid/ready handshake.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   i_load       : capture i_data this cycle (only asserted while o_free)
//   i_data       : packed word {count, buffer}
//   i_ready      : downstream writer accepts when o_valid & i_ready
//   o_valid      : a word is held
//   o_data       : held word, stable while o_valid & !i_ready
//   o_free       : register is empty or is being emptied this cycle
module nios2_oci_dct_outreg
  import nios2_oci_dct_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_load,
  input  logic [TW_W-1:0] i_data,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [TW_W-1:0] o_data,
  output logic            o_free
);

  logic            r_valid;
  logic [TW_W-1:0] r_data;

  // A new word may replace the current one in the same edge it is accepted.
  assign o_free  = ~r_valid | i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Hold register: load wins, otherwise empty on handshake, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
      r_data  <= r_data;
    end else begin
      r_valid <= r_valid;
      r_data  <= r_data;
    end
  end

endmodule

// File: rtl/nios2_oci_dct_packer.sv
// Trace-capture controller: packs 2-bit trace atoms into a 30-bit buffer,
// hands full or flushed words to the trace-memory writer, and sequences
// end-of-test draining.
// Ports:
//   clk, reset_n       : clock and asynchronous active-low reset
//   trace_enable       : 1 = accept atoms
//   atom_valid/_data   : atom offer; accepted when atom_valid & atom_ready
//   atom_ready         : combinational accept indication
//   flush_req          : level; rising edge requests a partial-word flush
//   flush_done         : one-cycle pulse when a flush completes
//   test_ending        : level; rising edge starts the end-of-test drain
//   test_has_ended     : sticky; all captured trace has left the block
//   tw_valid/_data     : packed word {count, buffer} to the writer
//   tw_ready           : writer accepts when tw_valid & tw_ready
//   dct_buffer/_count  : live capture buffer and atom count
module nios2_oci_dct_packer
  import nios2_oci_dct_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trace_enable,
  input  logic              atom_valid,
  input  logic [ATOM_W-1:0] atom_data,
  output logic              atom_ready,
  input  logic              flush_req,
  output logic              flush_done,
  input  logic              test_ending,
  output logic              test_has_ended,
  output logic              tw_valid,
  output logic [TW_W-1:0]   tw_data,
  input  logic              tw_ready,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count
);

  dct_state_t       r_state;
  logic [BUF_W-1:0] r_buffer;
  logic [CNT_W-1:0] r_count;
  logic             r_flush_pending;
  logic             r_flush_req_d;
  logic             r_test_ending_d;
  logic             r_flush_done;
  logic             r_test_has_ended;

  logic             w_accept;
  logic [BUF_W-1:0] w_next_buffer;
  logic [CNT_W-1:0] w_next_count;
  logic             w_trigger;
  logic             w_free;
  logic             w_load;
  logic             w_flush_rise;
  logic             w_drain_start;
  logic             w_flush_clear;

  assign atom_ready     = trace_enable & (r_state == COLLECT) & (r_count < CNT_FULL);
  assign w_accept       = atom_valid & atom_ready;
  assign w_flush_rise   = flush_req & ~r_flush_req_d;
  assign w_drain_start  = test_ending & ~r_test_ending_d & (r_state == COLLECT);
  assign w_load         = w_trigger & w_free;
  // A pending flush is satisfied once the buffer is (or is about to be) empty.
  assign w_flush_clear  = r_flush_pending & (w_load | (w_next_count == 4'd0));

  assign flush_done     = r_flush_done;
  assign test_has_ended = r_test_has_ended;
  assign dct_buffer     = r_buffer;
  assign dct_count      = r_count;

  // Buffer/count as they would be after this cycle's accept; hand-off uses these.
  always_comb begin
    w_next_buffer = r_buffer;
    w_next_count  = r_count;
    if (w_accept) begin
      w_next_buffer = {r_buffer[BUF_W-ATOM_W-1:0], atom_data};
      w_next_count  = r_count + 4'd1;
    end else begin
      w_next_buffer = r_buffer;
      w_next_count  = r_count;
    end
    w_trigger = (w_next_count == CNT_FULL) |
                (r_flush_pending & (w_next_count != 4'd0));
  end

  nios2_oci_dct_outreg u_outreg (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_data  ({w_next_count, w_next_buffer}),
    .i_ready (tw_ready),
    .o_valid (tw_valid),
    .o_data  (tw_data),
    .o_free  (w_free)
  );

  // Capture state, flush tracking and the end-of-test controller.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= COLLECT;
      r_buffer         <= '0;
      r_count          <= '0;
      r_flush_pending  <= 1'b0;
      r_flush_req_d    <= 1'b0;
      r_test_ending_d  <= 1'b0;
      r_flush_done     <= 1'b0;
      r_test_has_ended <= 1'b0;
    end else begin
      r_flush_req_d   <= flush_req;
      r_test_ending_d <= test_ending;

      if (w_load) begin
        r_buffer <= '0;
        r_count  <= '0;
      end else begin
        r_buffer <= w_next_buffer;
        r_count  <= w_next_count;
      end

      // A new request wins over a completion landing in the same cycle.
      r_flush_pending <= w_flush_rise | w_drain_start |
                         (r_flush_pending & ~w_flush_clear);
      r_flush_done    <= w_flush_clear;

      case (r_state)
        COLLECT: begin
          if (w_drain_start) begin
            r_state <= DRAIN;
          end else begin
            r_state <= COLLECT;
          end
        end
        DRAIN: begin
          if ((r_count == 4'd0) && !tw_valid) begin
            r_state          <= ENDED;
            r_test_has_ended <= 1'b1;
          end else begin
            r_state <= DRAIN;
          end
        end
        ENDED: begin
          r_state          <= ENDED;
          r_test_has_ended <= 1'b1;
        end
        default: begin
          r_state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
module tb_nios2_oci_dct_packer;

  logic        clk;
  logic        reset_n;
  logic        trace_enable;
  logic        atom_valid;
  logic [1:0]  atom_data;
  logic        atom_ready;
  logic        flush_req;
  logic        flush_done;
  logic        test_ending;
  logic        test_has_ended;
  logic        tw_valid;
  logic [33:0] tw_data;
  logic        tw_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;

  int total = 0;
  int bad   = 0;

  // Reference model: every accepted atom in order; each emitted word must
  // consist of the oldest not-yet-emitted atoms, oldest in the top bits.
  logic [1:0]  acc_q[$];
  logic        prev_hold;
  logic [33:0] prev_data;
  logic [29:0] mon_exp;
  int          mon_n;

  nios2_oci_dct_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .trace_enable   (trace_enable),
    .atom_valid     (atom_valid),
    .atom_data      (atom_data),
    .atom_ready     (atom_ready),
    .flush_req      (flush_req),
    .flush_done     (flush_done),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .tw_valid       (tw_valid),
    .tw_data        (tw_data),
    .tw_ready       (tw_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard on the negative edge, where inputs and outputs are settled.
  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_hold) begin
        total++;
        if (tw_valid !== 1'b1 || tw_data !== prev_data) begin
          bad++;
          $display("FAIL hold_stable: got valid=%b data=%h want valid=1 data=%h", tw_valid, tw_data, prev_data);
        end
      end
      if (tw_valid && tw_ready) begin
        mon_n = int'(tw_data[33:30]);
        total++;
        if (mon_n == 0 || mon_n > acc_q.size()) begin
          bad++;
          $display("FAIL word_count: got %0d with %0d atoms outstanding", mon_n, acc_q.size());
        end else begin
          mon_exp = 30'd0;
          for (int i = 0; i < mon_n; i++) mon_exp = (mon_exp << 2) | 30'(acc_q.pop_front());
          total++;
          if (tw_data[29:0] !== mon_exp) begin
            bad++;
            $display("FAIL word_data: got %h want %h", tw_data[29:0], mon_exp);
          end
        end
      end
      if (atom_valid && atom_ready) acc_q.push_back(atom_data);
      prev_hold = tw_valid & ~tw_ready;
      prev_data = tw_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic send_atom(input logic [1:0] a);
    int k;
    atom_valid = 1'b1;
    atom_data  = a;
    k = 0;
    while (!atom_ready && k < 60) begin
      tick();
      k++;
    end
    if (!atom_ready) begin
      total++;
      bad++;
      $display("FAIL send_atom_timeout: atom_ready=%b want 1", atom_ready);
    end
    tick();
    atom_valid = 1'b0;
  endtask

  task automatic do_flush();
    int k;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    k = 0;
    while (!flush_done && k < 60) begin
      tick();
      k++;
    end
    total++;
    if (!flush_done) begin
      bad++;
      $display("FAIL flush_timeout: flush_done=%b want 1", flush_done);
    end
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; trace_enable = 1'b1; atom_valid = 1'b0; atom_data = 2'd0;
    flush_req = 1'b0; test_ending = 1'b0; tw_ready = 1'b1;
    acc_q.delete();
    tick(); tick();
    total++;
    if ({tw_valid, tw_data, flush_done, test_has_ended, dct_buffer, dct_count} !== 70'd0) begin
      bad++;
      $display("FAIL reset_state: got v=%b d=%h fd=%b te=%b b=%h c=%0d want all 0",
               tw_valid, tw_data, flush_done, test_has_ended, dct_buffer, dct_count);
    end
    reset_n = 1'b1;
    tick();
    total++;
    if (atom_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1", atom_ready);
    end
  endtask

  task automatic test_stream();
    logic [29:0] v;
    v = 30'd0;
    tw_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      v = (v << 2) | 30'(i % 4);
      send_atom(2'(i % 4));
    end
    total++;
    if (tw_valid !== 1'b1 || tw_data !== {4'hF, v} || dct_count !== 4'd0) begin
      bad++;
      $display("FAIL stream_word: got v=%b d=%h c=%0d want v=1 d=%h c=0", tw_valid, tw_data, dct_count, {4'hF, v});
    end
    tick();
    total++;
    if (tw_valid !== 1'b0) begin
      bad++;
      $display("FAIL stream_drain: got tw_valid=%b want 0", tw_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  a[40];
    logic [29:0] w1, w2;
    w1 = 30'd0; w2 = 30'd0;
    for (int i = 0; i < 40; i++) a[i] = 2'($urandom);
    for (int i = 0; i < 15; i++) w1 = (w1 << 2) | 30'(a[i]);
    for (int i = 15; i < 30; i++) w2 = (w2 << 2) | 30'(a[i]);
    tw_ready = 1'b0;
    for (int i = 0; i < 30; i++) send_atom(a[i]);
    atom_valid = 1'b1;
    atom_data  = a[30];
    for (int k = 0; k < 3; k++) begin
      total++;
      if (atom_ready !== 1'b0 || dct_count !== 4'd15 || tw_valid !== 1'b1 || tw_data !== {4'hF, w1}) begin
        bad++;
        $display("FAIL bp_hold: got r=%b c=%0d v=%b d=%h want r=0 c=15 v=1 d=%h", atom_ready, dct_count, tw_valid, tw_data, {4'hF, w1});
      end
      tick();
    end
    tw_ready = 1'b1;
    tick();
    total++;
    if (tw_valid !== 1'b1 || tw_data !== {4'hF, w2} || dct_count !== 4'd0 || atom_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_word2: got v=%b d=%h c=%0d r=%b want v=1 d=%h c=0 r=1", tw_valid, tw_data, dct_count, atom_ready, {4'hF, w2});
    end
    tick();
    atom_valid = 1'b0;
    total++;
    if (tw_valid !== 1'b0 || dct_count !== 4'd1) begin
      bad++;
      $display("FAIL bp_resume: got v=%b c=%0d want v=0 c=1", tw_valid, dct_count);
    end
    for (int i = 31; i < 40; i++) send_atom(a[i]);
    total++;
    if (dct_count !== 4'd10) begin
      bad++;
      $display("FAIL bp_residual: got count=%0d want 10", dct_count);
    end
    do_flush();
  endtask

  task automatic test_flush();
    tw_ready = 1'b1;
    send_atom(2'd1); send_atom(2'd2); send_atom(2'd3);
    total++;
    if (dct_buffer !== 30'h1B || dct_count !== 4'd3) begin
      bad++;
      $display("FAIL flush_pre: got b=%h c=%0d want b=1b c=3", dct_buffer, dct_count);
    end
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    total++;
    if (tw_valid !== 1'b1 || tw_data !== {4'd3, 30'h1B} || flush_done !== 1'b1 || dct_count !== 4'd0) begin
      bad++;
      $display("FAIL flush_word: got v=%b d=%h fd=%b c=%0d want v=1 d=%h fd=1 c=0", tw_valid, tw_data, flush_done, dct_count, {4'd3, 30'h1B});
    end
    tick();
    total++;
    if (flush_done !== 1'b0 || tw_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_pulse: got fd=%b v=%b want fd=0 v=0", flush_done, tw_valid);
    end
  endtask

  task automatic test_flush_with_atom();
    logic [29:0] v;
    logic [1:0]  a;
    v = 30'd0;
    tw_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 2'($urandom);
      v = (v << 2) | 30'(a);
      send_atom(a);
    end
    v = (v << 2) | 30'd2;
    atom_valid = 1'b1; atom_data = 2'd2; flush_req = 1'b1;
    tick();
    atom_valid = 1'b0; flush_req = 1'b0;
    total++;
    if (dct_count !== 4'd5 || tw_valid !== 1'b0) begin
      bad++;
      $display("FAIL fwa_pre: got c=%0d v=%b want c=5 v=0", dct_count, tw_valid);
    end
    tick();
    total++;
    if (tw_valid !== 1'b1 || tw_data !== {4'd5, v} || tw_data[1:0] !== 2'd2) begin
      bad++;
      $display("FAIL fwa_word: got v=%b d=%h want v=1 d=%h", tw_valid, tw_data, {4'd5, v});
    end
    tick();
  endtask

  task automatic test_empty_flush();
    tw_ready = 1'b1;
    flush_req = 1'b1;
    tick();
    total++;
    if (flush_done !== 1'b0) begin
      bad++;
      $display("FAIL eflush_early: got flush_done=%b want 0", flush_done);
    end
    tick();
    total++;
    if (flush_done !== 1'b1 || tw_valid !== 1'b0) begin
      bad++;
      $display("FAIL eflush_pulse: got fd=%b v=%b want fd=1 v=0", flush_done, tw_valid);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (flush_done !== 1'b0 || tw_valid !== 1'b0) begin
        bad++;
        $display("FAIL eflush_retrigger: got fd=%b v=%b want fd=0 v=0", flush_done, tw_valid);
      end
    end
    flush_req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int k;
    for (int c = 0; c < 600; c++) begin
      if (!trace_enable) begin
        total++;
        if (atom_ready !== 1'b0) begin
          bad++;
          $display("FAIL rnd_enable: got atom_ready=%b want 0", atom_ready);
        end
      end
      if (tw_valid) begin
        total++;
        if (tw_data[33:30] !== 4'd15) begin
          bad++;
          $display("FAIL rnd_count: got %0d want 15", tw_data[33:30]);
        end
      end
      trace_enable = ($urandom_range(0, 7) != 0);
      atom_valid   = 1'($urandom_range(0, 1));
      atom_data    = 2'($urandom);
      tw_ready     = ($urandom_range(0, 3) != 0);
      tick();
    end
    atom_valid = 1'b0; trace_enable = 1'b1; tw_ready = 1'b1;
    do_flush();
    k = 0;
    while (tw_valid && k < 20) begin
      tick();
      k++;
    end
    total++;
    if (tw_valid !== 1'b0 || dct_count !== 4'd0 || acc_q.size() != 0) begin
      bad++;
      $display("FAIL rnd_drained: got v=%b c=%0d left=%0d want v=0 c=0 left=0", tw_valid, dct_count, acc_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    tw_ready = 1'b1;
    for (int i = 0; i < 9; i++) send_atom(2'($urandom));
    total++;
    if (dct_count !== 4'd9) begin
      bad++;
      $display("FAIL rmid_pre: got count=%0d want 9", dct_count);
    end
    reset_n = 1'b0;
    #1;
    acc_q.delete();
    total++;
    if ({tw_valid, tw_data, flush_done, test_has_ended, dct_buffer, dct_count} !== 70'd0) begin
      bad++;
      $display("FAIL rmid_reset: got v=%b d=%h fd=%b te=%b b=%h c=%0d want all 0",
               tw_valid, tw_data, flush_done, test_has_ended, dct_buffer, dct_count);
    end
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (tw_valid) seen = 1'b1;
    end
    total++;
    if (seen || atom_ready !== 1'b1 || dct_count !== 4'd0) begin
      bad++;
      $display("FAIL rmid_after: got emitted=%b r=%b c=%0d want emitted=0 r=1 c=0", seen, atom_ready, dct_count);
    end
  endtask

  task automatic test_end_drain();
    tw_ready = 1'b0;
    for (int i = 0; i < 7; i++) send_atom(2'($urandom));
    test_ending = 1'b1;
    tick();
    atom_valid = 1'b1; atom_data = 2'd1;
    total++;
    if (atom_ready !== 1'b0) begin
      bad++;
      $display("FAIL end_ready: got atom_ready=%b want 0", atom_ready);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (tw_valid !== 1'b1 || tw_data[33:30] !== 4'd7 || test_has_ended !== 1'b0 || atom_ready !== 1'b0) begin
        bad++;
        $display("FAIL end_wait: got v=%b c=%0d te=%b r=%b want v=1 c=7 te=0 r=0", tw_valid, tw_data[33:30], test_has_ended, atom_ready);
      end
      tick();
    end
    tw_ready = 1'b1;
    tick();
    tick();
    total++;
    if (test_has_ended !== 1'b1 || tw_valid !== 1'b0) begin
      bad++;
      $display("FAIL end_done: got te=%b v=%b want te=1 v=0", test_has_ended, tw_valid);
    end
    test_ending = 1'b0;
    tick();
    test_ending = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    total++;
    if (test_has_ended !== 1'b1 || atom_ready !== 1'b0 || tw_valid !== 1'b0) begin
      bad++;
      $display("FAIL end_sticky: got te=%b r=%b v=%b want te=1 r=0 v=0", test_has_ended, atom_ready, tw_valid);
    end
    atom_valid = 1'b0;
  endtask

  initial begin
    prev_hold = 1'b0;
    test_reset();
    test_stream();
    test_back_to_back();
    test_flush();
    test_flush_with_atom();
    test_empty_flush();
    test_random();
    test_reset_mid();
    test_end_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
